// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V sequencer: opcodes, FSM states,
// instruction classes and datapath mux/ALU select codes.
package riscv_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        C_R    = 3'd0,
        C_LW   = 3'd1,
        C_SW   = 3'd2,
        C_BEQ  = 3'd3,
        C_ADDI = 3'd4,
        C_ILL  = 3'd5
    } iclass_t;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I      = 2'b00;
    localparam logic [1:0] IMM_S      = 2'b01;
    localparam logic [1:0] IMM_B      = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

endpackage

// File: rtl/multicycle_fsm_op_decode.sv
// Opcode decode shared by the sequencer's DECODE branch and the immsrc output.
module op_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [1:0] immsrc,
    output logic [2:0] iclass,
    output logic       legal
);

    always_comb begin
        immsrc = IMM_I;
        iclass = C_ILL;
        legal  = 1'b1;
        case (opcode)
            OP_R:    iclass = C_R;
            OP_LW:   iclass = C_LW;
            OP_ADDI: iclass = C_ADDI;
            OP_SW: begin
                iclass = C_SW;
                immsrc = IMM_S;
            end
            OP_BEQ: begin
                iclass = C_BEQ;
                immsrc = IMM_B;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_fsm.sv
// Multi-cycle control sequencer: steps the shared datapath one phase per clock,
// owns the memory request handshake, the illegal-opcode trap and instret.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4 on completion
// DECODE   | read registers, branch target into ALUOut
// MEMADR   | compute load/store address
// MEMREAD  | load data request
// MEMWB    | write load data to register file
// MEMWRITE | store data request
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALU result to register file
// BEQ      | compare rs1/rs2, take branch on zero
// TRAP     | illegal opcode, parked until reset
module multicycle_fsm
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             adrsrc,
    output logic             memwrite,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             regwrite,
    output logic [1:0]       resultsrc,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       immsrc,
    output logic [1:0]       aluop,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t     state;
    logic [1:0] dec_immsrc;
    logic [2:0] op_class;
    logic       op_legal;
    logic       pcupdate;
    logic       branch;
    logic       retire;

    op_decode u_op_decode (
        .opcode (opcode),
        .immsrc (dec_immsrc),
        .iclass (op_class),
        .legal  (op_legal)
    );

    // A store retires on its completing edge; everything else on leaving its last phase.
    assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                    ((state == S_MEMWRITE) && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    if (!op_legal) begin
                        state   <= S_TRAP;
                        illegal <= 1'b1;
                    end else begin
                        case (op_class)
                            C_LW, C_SW: state <= S_MEMADR;
                            C_R:        state <= S_EXECR;
                            C_ADDI:     state <= S_EXECI;
                            C_BEQ:      state <= S_BEQ;
                            default: begin
                                state   <= S_TRAP;
                                illegal <= 1'b1;
                            end
                        endcase
                    end
                end
                S_MEMADR: begin
                    if (op_class == C_LW) begin
                        state <= S_MEMREAD;
                    end else if (op_class == C_SW) begin
                        state <= S_MEMWRITE;
                    end else begin
                        state   <= S_TRAP;
                        illegal <= 1'b1;
                    end
                end
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BEQ:      state <= S_FETCH;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_FETCH;
            endcase
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        adrsrc    = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        pcupdate  = 1'b0;
        regwrite  = 1'b0;
        branch    = 1'b0;
        resultsrc = RES_ALUOUT;
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_RS2;
        aluop     = ALU_ADD;
        immsrc    = dec_immsrc;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                irwrite   = mem_ready;
                pcupdate  = mem_ready;
                resultsrc = RES_ALU;
                alusrcb   = SRCB_FOUR;
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
            end
            S_MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adrsrc  = 1'b1;
            end
            S_MEMWB: begin
                resultsrc = RES_MEM;
                regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                adrsrc   = 1'b1;
            end
            S_EXECR: begin
                alusrca = SRCA_RS1;
                aluop   = ALU_FUNCT;
            end
            S_EXECI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                aluop   = ALU_FUNCT;
            end
            S_ALUWB:  regwrite = 1'b1;
            S_BEQ: begin
                alusrca = SRCA_RS1;
                aluop   = ALU_SUB;
                branch  = 1'b1;
            end
            default: ;
        endcase
        // State is already FETCH under reset, so only the strobes need masking.
        if (!rst_n) begin
            mem_req  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            pcupdate = 1'b0;
            regwrite = 1'b0;
            branch   = 1'b0;
        end
    end

    assign pcwrite = pcupdate | (branch & zero);

endmodule

// File: tb/tb_multicycle_fsm.sv
// Scoreboard bench for multicycle_fsm: directed per-cycle state sequences push
// expected control words; a negedge monitor pops and compares.
module tb_multicycle_fsm;

    localparam int T_FETCH    = 0;
    localparam int T_DECODE   = 1;
    localparam int T_MEMADR   = 2;
    localparam int T_MEMREAD  = 3;
    localparam int T_MEMWB    = 4;
    localparam int T_MEMWRITE = 5;
    localparam int T_EXECR    = 6;
    localparam int T_EXECI    = 7;
    localparam int T_ALUWB    = 8;
    localparam int T_BEQ      = 9;
    localparam int T_TRAP     = 10;
    localparam int T_RST      = 15;

    localparam logic [6:0] O_R    = 7'b0110011;
    localparam logic [6:0] O_LW   = 7'b0000011;
    localparam logic [6:0] O_SW   = 7'b0100011;
    localparam logic [6:0] O_BEQ  = 7'b1100011;
    localparam logic [6:0] O_ADDI = 7'b0010011;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic [31:0] ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic        mem_req, adrsrc, memwrite, irwrite, pcwrite, regwrite, illegal;
    logic [1:0]  resultsrc, alusrca, alusrcb, immsrc, aluop;
    logic [31:0] instret;

    logic        mem_req4, adrsrc4, memwrite4, irwrite4, pcwrite4, regwrite4, illegal4;
    logic [1:0]  resultsrc4, alusrca4, alusrcb4, immsrc4, aluop4;
    logic [3:0]  instret4;

    logic [16:0] ctrl_a, ctrl_b;
    exp_t        sbq[$];
    exp_t        mon_e;
    logic [6:0]  cur_op;
    logic [31:0] exp_ret;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    multicycle_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite),
        .pcwrite(pcwrite), .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .immsrc(immsrc), .aluop(aluop), .illegal(illegal),
        .instret(instret)
    );

    multicycle_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req4), .adrsrc(adrsrc4), .memwrite(memwrite4), .irwrite(irwrite4),
        .pcwrite(pcwrite4), .regwrite(regwrite4), .resultsrc(resultsrc4), .alusrca(alusrca4),
        .alusrcb(alusrcb4), .immsrc(immsrc4), .aluop(aluop4), .illegal(illegal4),
        .instret(instret4)
    );

    assign ctrl_a = {mem_req, adrsrc, memwrite, irwrite, pcwrite, regwrite,
                     resultsrc, alusrca, alusrcb, immsrc, aluop, illegal};
    assign ctrl_b = {mem_req4, adrsrc4, memwrite4, irwrite4, pcwrite4, regwrite4,
                     resultsrc4, alusrca4, alusrcb4, immsrc4, aluop4, illegal4};

    function automatic logic [16:0] exp_ctrl(input int st, input logic rdy,
                                              input logic z, input logic [6:0] op);
        logic mreq, adr, mw, irw, pcw, rw, ill;
        logic [1:0] res, sa, sb, imm, aop;
        {mreq, adr, mw, irw, pcw, rw, ill} = 7'b0;
        {res, sa, sb, aop} = 8'b0;
        imm = (op == O_SW) ? 2'b01 : (op == O_BEQ) ? 2'b10 : 2'b00;
        case (st)
            T_RST:      begin res = 2'b10; sb = 2'b10; end
            T_FETCH:    begin mreq = 1; irw = rdy; pcw = rdy; res = 2'b10; sb = 2'b10; end
            T_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            T_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            T_MEMREAD:  begin mreq = 1; adr = 1; end
            T_MEMWB:    begin res = 2'b01; rw = 1; end
            T_MEMWRITE: begin mreq = 1; mw = 1; adr = 1; end
            T_EXECR:    begin sa = 2'b10; aop = 2'b10; end
            T_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            T_ALUWB:    rw = 1;
            T_BEQ:      begin sa = 2'b10; aop = 2'b01; pcw = z; end
            T_TRAP:     ill = 1;
            default:    ;
        endcase
        return {mreq, adr, mw, irw, pcw, rw, res, sa, sb, imm, aop, ill};
    endfunction

    // One clock of stimulus; called just after a rising edge.
    task automatic cyc(input int st, input logic rdy, input logic z, input logic ret_here);
        exp_t e;
        mem_ready = rdy;
        zero      = z;
        opcode    = cur_op;
        e.st      = st[3:0];
        e.ctrl    = exp_ctrl(st, rdy, z, cur_op);
        e.ret     = exp_ret;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (ret_here) exp_ret = exp_ret + 32'd1;
    endtask

    task automatic run_r();
        cyc(T_FETCH, 1, 0, 0);
        cyc(T_DECODE, 1, 0, 0);
        cyc(T_EXECR, 1, 0, 0);
        cyc(T_ALUWB, 1, 0, 1);
    endtask

    task automatic pulse_reset();
        rst_n   = 1'b0;
        exp_ret = 32'd0;
        cyc(T_RST, 1, 0, 0);
        rst_n   = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks++;
            if (ctrl_a !== mon_e.ctrl) begin
                errors++;
                $display("FAIL ctrl st=%0d t=%0t got=%b exp=%b", mon_e.st, $time, ctrl_a, mon_e.ctrl);
            end
            checks++;
            if (ctrl_b !== mon_e.ctrl) begin
                errors++;
                $display("FAIL ctrl4 st=%0d t=%0t got=%b exp=%b", mon_e.st, $time, ctrl_b, mon_e.ctrl);
            end
            checks++;
            if (instret !== mon_e.ret) begin
                errors++;
                $display("FAIL instret st=%0d t=%0t got=%0d exp=%0d", mon_e.st, $time, instret, mon_e.ret);
            end
            checks++;
            if (instret4 !== mon_e.ret[3:0]) begin
                errors++;
                $display("FAIL instret4 st=%0d t=%0t got=%0d exp=%0d", mon_e.st, $time, instret4, mon_e.ret[3:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cur_op  = O_ADDI;
        exp_ret = 32'd0;
        @(posedge clk);
        #1;
        // reset: strobes masked even with mem_ready high
        cyc(T_RST, 1, 0, 0);
        cyc(T_RST, 1, 0, 0);
        rst_n = 1'b1;

        // ADDI, zero-wait
        cyc(T_FETCH, 1, 0, 0);
        cyc(T_DECODE, 1, 0, 0);
        cyc(T_EXECI, 1, 0, 0);
        cyc(T_ALUWB, 1, 0, 1);

        // LW with 3 wait cycles in MEMREAD
        cur_op = O_LW;
        cyc(T_FETCH, 1, 0, 0);
        cyc(T_DECODE, 1, 0, 0);
        cyc(T_MEMADR, 1, 0, 0);
        cyc(T_MEMREAD, 0, 0, 0);
        cyc(T_MEMREAD, 0, 0, 0);
        cyc(T_MEMREAD, 0, 0, 0);
        cyc(T_MEMREAD, 1, 0, 0);
        cyc(T_MEMWB, 1, 0, 1);

        // BEQ taken then not taken
        cur_op = O_BEQ;
        cyc(T_FETCH, 1, 1, 0);
        cyc(T_DECODE, 1, 1, 0);
        cyc(T_BEQ, 1, 1, 1);
        cyc(T_FETCH, 1, 0, 0);
        cyc(T_DECODE, 1, 1, 0);
        cyc(T_BEQ, 1, 0, 1);

        // SW with a fetch wait and a store wait
        cur_op = O_SW;
        cyc(T_FETCH, 0, 0, 0);
        cyc(T_FETCH, 1, 0, 0);
        cyc(T_DECODE, 1, 0, 0);
        cyc(T_MEMADR, 1, 0, 0);
        cyc(T_MEMWRITE, 0, 0, 0);
        cyc(T_MEMWRITE, 1, 0, 1);

        cur_op = O_R;
        run_r();

        // reset during a store wait abandons it
        cur_op = O_SW;
        cyc(T_FETCH, 1, 0, 0);
        cyc(T_DECODE, 1, 0, 0);
        cyc(T_MEMADR, 1, 0, 0);
        cyc(T_MEMWRITE, 0, 0, 0);
        rst_n   = 1'b0;
        exp_ret = 32'd0;
        cyc(T_RST, 0, 0, 0);
        rst_n = 1'b1;
        cyc(T_FETCH, 1, 0, 0);
        cyc(T_DECODE, 1, 0, 0);
        cyc(T_MEMADR, 1, 0, 0);
        cyc(T_MEMWRITE, 1, 0, 1);

        // illegal opcode parks in TRAP until reset
        cur_op = 7'b1111111;
        cyc(T_FETCH, 1, 0, 0);
        cyc(T_DECODE, 1, 0, 0);
        for (int i = 0; i < 20; i++) cyc(T_TRAP, 1, 1, 0);
        pulse_reset();

        cur_op = 7'b0110111;
        cyc(T_FETCH, 1, 0, 0);
        cyc(T_DECODE, 1, 0, 0);
        cyc(T_TRAP, 1, 0, 0);
        cyc(T_TRAP, 0, 1, 0);
        pulse_reset();

        // 17 R instructions: 4-bit counter wraps to 1
        cur_op = O_R;
        for (int i = 0; i < 17; i++) run_r();
        cyc(T_FETCH, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
